// File: rtl/cache_refill_if.sv
// Core/tag-store/memory-side handshake bundle for the cache refill controller.
// The slave modport is the controller; the master modport is its environment.
interface cache_refill_if #(
    parameter int unsigned TAG_WIDTH   = 4,
    parameter int unsigned INDEX_WIDTH = 4,
    parameter int unsigned WAY_NUM     = 4,
    parameter int unsigned LINE_WIDTH  = 32
) ();
    localparam int unsigned ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH;

    logic                   lookup_valid;
    logic [TAG_WIDTH-1:0]   tag;
    logic [INDEX_WIDTH-1:0] index;
    logic [WAY_NUM-1:0]     hit_en;
    logic                   lookup_ready;
    logic                   miss_busy;

    logic                   mem_req_valid;
    logic [ADDR_WIDTH-1:0]  mem_req_addr;
    logic                   mem_req_ready;
    logic                   mem_resp_valid;
    logic [LINE_WIDTH-1:0]  mem_resp_data;

    logic                   read_main_memory_en;
    logic [ADDR_WIDTH-1:0]  addr_to_main_memory;
    logic [WAY_NUM-1:0]     replaced_way;
    logic [LINE_WIDTH-1:0]  fill_data;
    logic                   refill_done;

    modport master (
        output lookup_valid, tag, index, hit_en,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  lookup_ready, miss_busy, mem_req_valid, mem_req_addr,
        input  read_main_memory_en, addr_to_main_memory, replaced_way,
        input  fill_data, refill_done
    );

    modport slave (
        input  lookup_valid, tag, index, hit_en,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output lookup_ready, miss_busy, mem_req_valid, mem_req_addr,
        output read_main_memory_en, addr_to_main_memory, replaced_way,
        output fill_data, refill_done
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss handler for the 4-way cache: victim choice (first invalid, else tree PLRU),
// main-memory fetch over valid/ready, and a one-cycle fill strobe to the tag/data stores.
module cache_refill_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    cache_refill_if.slave  bus
);
    localparam int unsigned TAG_WIDTH   = 4;
    localparam int unsigned INDEX_WIDTH = 4;
    localparam int unsigned ADDR_WIDTH  = TAG_WIDTH + INDEX_WIDTH;
    localparam int unsigned WAY_NUM     = 4;
    localparam int unsigned WAY_IDX_W   = 2;
    localparam int unsigned PLRU_W      = 3;
    localparam int unsigned LINE_WIDTH  = 32;
    localparam int unsigned LINE_NUM    = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [WAY_IDX_W-1:0]   victim_q, victim_d;
    logic [PLRU_W-1:0]      plru_q  [LINE_NUM];
    logic [WAY_NUM-1:0]     vmask_q [LINE_NUM];

    logic [WAY_NUM-1:0]     line_vmask;
    logic [PLRU_W-1:0]      line_plru;
    logic                   hit_upd;
    logic [WAY_IDX_W-1:0]   hit_way;
    logic                   fill_upd;
    logic [INDEX_WIDTH-1:0] fill_index;

    function automatic logic [WAY_IDX_W-1:0] lowest_set(input logic [WAY_NUM-1:0] v);
        logic [WAY_IDX_W-1:0] w;
        if (v[0])      w = 2'd0;
        else if (v[1]) w = 2'd1;
        else if (v[2]) w = 2'd2;
        else           w = 2'd3;
        return w;
    endfunction

    // Bits are {b2,b1,b0}: b0 picks the pair, b1/b2 pick within the low/high pair.
    function automatic logic [WAY_IDX_W-1:0] plru_victim(input logic [PLRU_W-1:0] p);
        logic [WAY_IDX_W-1:0] w;
        if (!p[0]) w = p[1] ? 2'd1 : 2'd0;
        else       w = p[2] ? 2'd3 : 2'd2;
        return w;
    endfunction

    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] p,
                                                     input logic [WAY_IDX_W-1:0] w);
        logic [PLRU_W-1:0] r;
        r = p;
        if (!w[1]) begin
            r[0] = 1'b1;
            r[1] = (w == 2'd0);
        end else begin
            r[0] = 1'b0;
            r[2] = (w == 2'd2);
        end
        return r;
    endfunction

    assign fill_index = addr_q[ADDR_WIDTH-1:TAG_WIDTH];

    // Next-state, victim choice and replacement-state update requests
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        victim_d   = victim_q;
        hit_upd    = 1'b0;
        fill_upd   = 1'b0;
        hit_way    = lowest_set(bus.hit_en);
        line_vmask = vmask_q[bus.index];
        line_plru  = plru_q[bus.index];
        case (state_q)
            IDLE: begin
                if (bus.lookup_valid) begin
                    if (bus.hit_en != '0) begin
                        hit_upd = 1'b1;
                    end else begin
                        addr_d   = {bus.index, bus.tag};
                        victim_d = (&line_vmask) ? plru_victim(line_plru)
                                                 : lowest_set(~line_vmask);
                        state_d  = REQ;
                    end
                end
            end
            REQ:  if (bus.mem_req_ready)  state_d = WAIT;
            WAIT: if (bus.mem_resp_valid) state_d = FILL;
            FILL: begin
                fill_upd = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, replacement bookkeeping and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            victim_q <= '0;
            for (int i = 0; i < int'(LINE_NUM); i++) begin
                plru_q[i]  <= '0;
                vmask_q[i] <= '0;
            end
            bus.lookup_ready        <= 1'b1;
            bus.miss_busy           <= 1'b0;
            bus.mem_req_valid       <= 1'b0;
            bus.mem_req_addr        <= '0;
            bus.read_main_memory_en <= 1'b0;
            bus.refill_done         <= 1'b0;
            bus.addr_to_main_memory <= '0;
            bus.replaced_way        <= '0;
            bus.fill_data           <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            victim_q <= victim_d;
            if (hit_upd)
                plru_q[bus.index] <= plru_touch(plru_q[bus.index], hit_way);
            if (fill_upd) begin
                vmask_q[fill_index][victim_q] <= 1'b1;
                plru_q[fill_index]            <= plru_touch(plru_q[fill_index], victim_q);
            end
            bus.lookup_ready        <= (state_d == IDLE);
            bus.miss_busy           <= (state_d != IDLE);
            bus.mem_req_valid       <= (state_d == REQ);
            bus.mem_req_addr        <= (state_d == REQ) ? addr_d : '0;
            bus.read_main_memory_en <= (state_d == FILL);
            bus.refill_done         <= (state_d == FILL);
            bus.addr_to_main_memory <= (state_d == FILL) ? addr_d : '0;
            bus.replaced_way        <= (state_d == FILL) ? (WAY_NUM'(1) << victim_d) : '0;
            // FILL is only entered on a WAIT response, so the bus data is the line
            bus.fill_data           <= (state_d == FILL) ? bus.mem_resp_data : LINE_WIDTH'(0);
        end
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomised scoreboard bench for cache_refill_ctrl against a recency-based PLRU model.
module tb_cache_refill_ctrl;
    logic clk;
    logic rst_n;

    cache_refill_if bus ();

    cache_refill_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [3:0]  way;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: per line, which ways hold data, which pair was used last,
    // and which way was used last inside each pair. Victim is the least recent side.
    bit ref_valid [16][4];
    int last_pair [16];
    int last_in   [16][2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_reset();
        for (int i = 0; i < 16; i++) begin
            for (int w = 0; w < 4; w++) ref_valid[i][w] = 1'b0;
            last_pair[i]  = 1;
            last_in[i][0] = 1;
            last_in[i][1] = 3;
        end
    endfunction

    function automatic int ref_victim(input int idx);
        int p;
        for (int w = 0; w < 4; w++)
            if (!ref_valid[idx][w]) return w;
        p = 1 - last_pair[idx];
        return (last_in[idx][p] == 2 * p) ? 2 * p + 1 : 2 * p;
    endfunction

    function automatic void ref_touch(input int idx, input int w);
        last_pair[idx]      = w / 2;
        last_in[idx][w / 2] = w;
    endfunction

    function automatic int lowest(input logic [3:0] h);
        for (int w = 0; w < 4; w++) if (h[w]) return w;
        return 0;
    endfunction

    task automatic idle_inputs();
        bus.lookup_valid   = 1'b0;
        bus.tag            = '0;
        bus.index          = '0;
        bus.hit_en         = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_lookup_ready", 32'(bus.lookup_ready), 32'd1);
        chk("rst_miss_busy", 32'(bus.miss_busy), 32'd0);
        chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_req_addr", 32'(bus.mem_req_addr), 32'd0);
        chk("rst_fill_en", 32'(bus.read_main_memory_en), 32'd0);
        chk("rst_fill_addr", 32'(bus.addr_to_main_memory), 32'd0);
        chk("rst_replaced_way", 32'(bus.replaced_way), 32'd0);
        chk("rst_fill_data", bus.fill_data, 32'd0);
        chk("rst_refill_done", 32'(bus.refill_done), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_reset_outputs();
        ref_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_lookup(input int idx);
        bus.lookup_valid = 1'($urandom);
        bus.hit_en       = 4'($urandom);
        bus.index        = ($urandom_range(0, 1) == 0) ? 4'(idx) : 4'($urandom);
        bus.tag          = 4'($urandom);
    endtask

    task automatic do_hits(input int idx, input int n);
        logic [3:0] h;
        @(posedge clk); #1;
        chk("hit_idle_ready", 32'(bus.lookup_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            h = 4'($urandom_range(1, 15));
            bus.lookup_valid = 1'b1;
            bus.index        = 4'(idx);
            bus.tag          = 4'($urandom);
            bus.hit_en       = h;
            ref_touch(idx, lowest(h));
            @(posedge clk); #1;
            chk("hit_stays_idle", 32'(bus.lookup_ready), 32'd1);
        end
        bus.lookup_valid = 1'b0;
        bus.hit_en       = '0;
    endtask

    task automatic do_hit_way(input int idx, input logic [3:0] h);
        @(posedge clk); #1;
        bus.lookup_valid = 1'b1;
        bus.index        = 4'(idx);
        bus.hit_en       = h;
        ref_touch(idx, lowest(h));
        @(posedge clk); #1;
        bus.lookup_valid = 1'b0;
        bus.hit_en       = '0;
    endtask

    task automatic do_miss(input int idx, input int tg, input int stall, input int resp_wait,
                           input bit early, input logic [31:0] data, input bit abort);
        exp_t       e;
        int         v;
        logic [7:0] a;
        a = {4'(idx), 4'(tg)};
        @(posedge clk); #1;
        chk("miss_idle_ready", 32'(bus.lookup_ready), 32'd1);
        if (!abort) begin
            v      = ref_victim(idx);
            e.addr = a;
            e.way  = 4'(1 << v);
            e.data = data;
            exp_q.push_back(e);
            ref_valid[idx][v] = 1'b1;
            ref_touch(idx, v);
        end
        bus.lookup_valid = 1'b1;
        bus.index        = 4'(idx);
        bus.tag          = 4'(tg);
        bus.hit_en       = '0;
        @(posedge clk); #1;
        for (int i = 0; i <= stall; i++) begin
            bus.mem_req_ready  = (i == stall);
            bus.mem_resp_valid = 1'b0;
            if (i < stall) rand_lookup(idx);
            else           bus.lookup_valid = 1'b0;
            if (early && i == 0 && stall > 0) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = 32'hBAD0_BAD0;
            end
            chk("req_valid", 32'(bus.mem_req_valid), 32'd1);
            chk("req_addr", 32'(bus.mem_req_addr), 32'(a));
            chk("req_not_ready", 32'(bus.lookup_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.lookup_valid   = 1'b0;
        chk("wait_busy", 32'(bus.miss_busy), 32'd1);
        chk("wait_req_dropped", 32'(bus.mem_req_valid), 32'd0);
        for (int j = 0; j < resp_wait; j++) begin
            rand_lookup(idx);
            @(posedge clk); #1;
        end
        bus.lookup_valid = 1'b0;
        if (abort) begin
            do_reset();
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 32'h5EA1_DA7A;
            @(posedge clk); #1;
            bus.mem_resp_valid = 1'b0;
            @(posedge clk); #1;
            chk("stale_resp_idle", 32'(bus.lookup_ready), 32'd1);
            chk("stale_resp_no_fill", 32'(bus.read_main_memory_en), 32'd0);
            return;
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = data;
        rand_lookup(idx);
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;
        bus.lookup_valid   = 1'b0;
        chk("fill_not_ready", 32'(bus.lookup_ready), 32'd0);
        @(posedge clk); #1;
        chk("post_fill_ready", 32'(bus.lookup_ready), 32'd1);
        chk("post_fill_busy", 32'(bus.miss_busy), 32'd0);
    endtask

    // Scoreboard monitor: every fill strobe must match the oldest outstanding miss
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.read_main_memory_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe actual way=%b addr=%h required none",
                             bus.replaced_way, bus.addr_to_main_memory);
                end else begin
                    e = exp_q.pop_front();
                    chk("fill_way", 32'(bus.replaced_way), 32'(e.way));
                    chk("fill_addr", 32'(bus.addr_to_main_memory), 32'(e.addr));
                    chk("fill_data", bus.fill_data, e.data);
                    chk("fill_done", 32'(bus.refill_done), 32'd1);
                end
            end else begin
                chk("quiet_way", 32'(bus.replaced_way), 32'd0);
                chk("quiet_done", 32'(bus.refill_done), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, rw, idx;
        rst_n = 1'b0;
        idle_inputs();
        ref_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // Cold miss: ready in the first REQ cycle, response one cycle into WAIT
        do_miss(3, 5, 0, 1, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Replacement order on one set, then PLRU victim after a hit
        do_reset();
        for (int t = 1; t <= 4; t++) do_miss(3, t, 0, 0, 1'b0, 32'h1000_0000 + 32'(t), 1'b0);
        do_miss(3, 6, 0, 0, 1'b0, 32'h0000_0005, 1'b0);
        do_hit_way(3, 4'b0001);
        do_miss(3, 7, 0, 0, 1'b0, 32'h0000_0006, 1'b0);

        // Long request stall with lookup noise, then a miss whose victim depends on PLRU
        do_miss(3, 8, 5, 0, 1'b0, 32'hCAFE_0001, 1'b0);
        do_miss(3, 9, 0, 2, 1'b0, 32'hCAFE_0002, 1'b0);

        // Early response pulse while still in REQ
        do_miss(3, 10, 2, 1, 1'b1, 32'h0123_4567, 1'b0);

        // Reset while waiting for memory, then a clean miss
        do_miss(3, 11, 1, 1, 1'b0, 32'h0, 1'b1);
        do_miss(3, 12, 0, 0, 1'b0, 32'h7777_0003, 1'b0);

        // Sets are independent
        do_reset();
        do_miss(0, 2, 0, 0, 1'b0, 32'hA0A0_0000, 1'b0);
        do_miss(15, 9, 0, 0, 1'b0, 32'hF0F0_000F, 1'b0);

        // Random mix of hit bursts and misses on a few sets
        for (int it = 0; it < 60; it++) begin
            idx = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) begin
                do_hits(idx, $urandom_range(1, 3));
            end else begin
                st = $urandom_range(0, 3);
                rw = $urandom_range(0, 3);
                do_miss(idx, $urandom_range(0, 15), st, rw, (st > 0) && ($urandom_range(0, 1) == 1),
                        $urandom, 1'b0);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
